// File: rtl/pulse_rate_pkg.sv
// ---------------------------------------------------------------------------
// pulse_rate_pkg
// Shared definitions for the pulse rate monitor:
//   - state_e      : FSM state encoding (IDLE, MEASURE)
//   - DEF_*        : default parameter values for the monitor
//   - clog2()      : ceiling log2, used to size the window counter
// ---------------------------------------------------------------------------
package pulse_rate_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  localparam int DEF_WINDOW_CYCLES = 256;
  localparam int DEF_CNT_W         = 8;
  localparam int DEF_LOW_THRESH    = 4;
  localparam int DEF_HIGH_THRESH   = 200;

  // Number of bits needed to hold the values 0 .. value-1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/pulse_edge_detect.sv
// ---------------------------------------------------------------------------
// pulse_edge_detect
// Registers the incoming pulse stream every cycle and flags rising edges.
// Ports:
//   i_clk    : system clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_pulse  : pulse stream, synchronous to i_clk
//   o_edge   : high in the cycle where i_pulse is 1 and was 0 the cycle before
// ---------------------------------------------------------------------------
module pulse_edge_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pulse,
  output logic o_edge
);

  logic pulse_d_q;
  logic pulse_d_d;

  always_comb begin
    pulse_d_d = i_pulse;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pulse_d_q <= 1'b0;
    end else begin
      pulse_d_q <= pulse_d_d;
    end
  end

  // A level held high produces a single edge on its first cycle only.
  assign o_edge = i_pulse & ~pulse_d_q;

endmodule

// File: rtl/pulse_rate_monitor.sv
// ---------------------------------------------------------------------------
// pulse_rate_monitor
// Counts rising edges of i_pulse over back-to-back windows of WINDOW_CYCLES
// clocks and reports each window's count with a one-cycle valid strobe,
// flagging under-rate and over-rate against static thresholds.
//
// Ports:
//   i_clk        : system clock, rising edge
//   i_rst_n      : asynchronous active-low reset
//   i_pulse      : pulse stream under test
//   i_en         : run enable (level)
//   o_count      : edge count of last completed window, held until next report
//   o_valid      : one-cycle strobe, o_count/o_under/o_over updated this cycle
//   o_under      : last window count < LOW_THRESH
//   o_over       : last window count > HIGH_THRESH or counter saturated
//   o_busy       : high while measuring
//   i_alarm_clr  : (PULSE_RATE_MON_ALARM_EN only) clears o_alarm
//   o_alarm      : (PULSE_RATE_MON_ALARM_EN only) sticky out-of-range alarm
//
// Optional feature macro: PULSE_RATE_MON_ALARM_EN adds the sticky alarm.
// If LOW_THRESH > HIGH_THRESH both flags may assert together; that setup is
// legal but almost certainly a misconfiguration.
// ---------------------------------------------------------------------------
module pulse_rate_monitor
  import pulse_rate_pkg::*;
#(
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int LOW_THRESH    = DEF_LOW_THRESH,
  parameter int HIGH_THRESH   = DEF_HIGH_THRESH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pulse,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_valid,
  output logic             o_under,
  output logic             o_over,
`ifdef PULSE_RATE_MON_ALARM_EN
  input  logic             i_alarm_clr,
  output logic             o_alarm,
`endif
  output logic             o_busy
);

  localparam int                 WIN_W    = (clog2(WINDOW_CYCLES) < 1) ? 1 : clog2(WINDOW_CYCLES);
  localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
  localparam logic [31:0]        LOW_T    = 32'(LOW_THRESH);
  localparam logic [31:0]        HIGH_T   = 32'(HIGH_THRESH);

  state_e             state_q, state_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic               sat_q, sat_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               valid_q, valid_d;
  logic               under_q, under_d;
  logic               over_q, over_d;

  logic               pulse_edge;
  logic [CNT_W-1:0]   final_cnt;
  logic               final_sat;
  logic               last_cycle;

  pulse_edge_detect u_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_pulse (i_pulse),
    .o_edge  (pulse_edge)
  );

  // Running count including this cycle's edge. Once the counter sits at its
  // maximum, further edges only set the sticky saturation bit.
  always_comb begin
    final_cnt = edge_cnt_q;
    final_sat = sat_q;
    if (pulse_edge) begin
      if (edge_cnt_q == CNT_MAX) begin
        final_sat = 1'b1;
      end else begin
        final_cnt = edge_cnt_q + CNT_W'(1);
      end
    end
    last_cycle = (state_q == MEASURE) && (win_cnt_q == WIN_LAST);
  end

  // Next-state logic. The report is taken on the last window cycle even if
  // i_en drops in that same cycle; the following window starts with no gap.
  always_comb begin
    state_d    = state_q;
    win_cnt_d  = win_cnt_q;
    edge_cnt_d = edge_cnt_q;
    sat_d      = sat_q;
    count_d    = count_q;
    under_d    = under_q;
    over_d     = over_q;
    valid_d    = 1'b0;

    case (state_q)
      IDLE: begin
        win_cnt_d  = '0;
        edge_cnt_d = '0;
        sat_d      = 1'b0;
        if (i_en) begin
          state_d = MEASURE;
        end
      end

      MEASURE: begin
        if (last_cycle) begin
          count_d    = final_cnt;
          under_d    = (32'(final_cnt) < LOW_T);
          over_d     = (32'(final_cnt) > HIGH_T) || final_sat;
          valid_d    = 1'b1;
          win_cnt_d  = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
          state_d    = i_en ? MEASURE : IDLE;
        end else if (!i_en) begin
          win_cnt_d  = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
          state_d    = IDLE;
        end else begin
          win_cnt_d  = win_cnt_q + WIN_W'(1);
          edge_cnt_d = final_cnt;
          sat_d      = final_sat;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      win_cnt_q  <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      under_q    <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_cnt_q  <= win_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sat_q      <= sat_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      under_q    <= under_d;
      over_q     <= over_d;
    end
  end

`ifdef PULSE_RATE_MON_ALARM_EN
  logic alarm_q, alarm_d;

  // Sticky alarm: an out-of-range report overrides a simultaneous clear.
  always_comb begin
    alarm_d = alarm_q;
    if (i_alarm_clr) begin
      alarm_d = 1'b0;
    end
    if (valid_d && (under_d || over_d)) begin
      alarm_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign o_alarm = alarm_q;
`endif

  assign o_count = count_q;
  assign o_valid = valid_q;
  assign o_under = under_q;
  assign o_over  = over_q;
  assign o_busy  = (state_q == MEASURE);

endmodule

// File: tb/tb_pulse_rate_monitor.sv
// ---------------------------------------------------------------------------
// tb_pulse_rate_monitor
// Directed bench for pulse_rate_monitor. Two instances share stimulus:
//   dut1 : WINDOW_CYCLES=16, CNT_W=8, LOW_THRESH=2, HIGH_THRESH=6
//   dut2 : WINDOW_CYCLES=16, CNT_W=3, LOW_THRESH=2, HIGH_THRESH=7
// dut2's HIGH_THRESH equals its counter maximum, so its o_over can only come
// from saturation. Alarm checks exist when PULSE_RATE_MON_ALARM_EN is set.
// ---------------------------------------------------------------------------
module tb_pulse_rate_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pulse = 1'b0;
  logic       en = 1'b0;
  logic       alarm_clr = 1'b0;

  logic [7:0] c1_count;
  logic       c1_valid, c1_under, c1_over, c1_busy;
  logic [2:0] c2_count;
  logic       c2_valid, c2_under, c2_over, c2_busy;
`ifdef PULSE_RATE_MON_ALARM_EN
  logic       c1_alarm, c2_alarm;
`endif

  int n_compared = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  pulse_rate_monitor #(
    .WINDOW_CYCLES(16), .CNT_W(8), .LOW_THRESH(2), .HIGH_THRESH(6)
  ) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pulse(pulse), .i_en(en),
    .o_count(c1_count), .o_valid(c1_valid), .o_under(c1_under), .o_over(c1_over),
`ifdef PULSE_RATE_MON_ALARM_EN
    .i_alarm_clr(alarm_clr), .o_alarm(c1_alarm),
`endif
    .o_busy(c1_busy)
  );

  pulse_rate_monitor #(
    .WINDOW_CYCLES(16), .CNT_W(3), .LOW_THRESH(2), .HIGH_THRESH(7)
  ) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pulse(pulse), .i_en(en),
    .o_count(c2_count), .o_valid(c2_valid), .o_under(c2_under), .o_over(c2_over),
`ifdef PULSE_RATE_MON_ALARM_EN
    .i_alarm_clr(alarm_clr), .o_alarm(c2_alarm),
`endif
    .o_busy(c2_busy)
  );

  // Advance one clock and settle 1 ns past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset both DUTs with the given pulse level, release, then sit one IDLE cycle.
  task automatic start_from_reset(input logic lvl);
    en = 1'b0;
    alarm_clr = 1'b0;
    pulse = lvl;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Raise enable; after this returns the DUTs are in window cycle 0.
  task automatic enter_measure(input logic lvl);
    en = 1'b1;
    pulse = lvl;
    tick();
  endtask

  task automatic test_reset();
    pulse = 1'b0;
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_compared++;
    if ({c1_count, c1_valid, c1_under, c1_over, c1_busy} !== 12'h000) begin
      n_mismatched++;
      $display("[TB] FAIL reset_dut1 actual=%h/%b%b%b%b required=00/0000", c1_count, c1_valid, c1_under, c1_over, c1_busy);
    end
    n_compared++;
    if ({c2_count, c2_valid, c2_under, c2_over, c2_busy} !== 7'h00) begin
      n_mismatched++;
      $display("[TB] FAIL reset_dut2 actual=%h/%b%b%b%b required=0/0000", c2_count, c2_valid, c2_under, c2_over, c2_busy);
    end
`ifdef PULSE_RATE_MON_ALARM_EN
    n_compared++;
    if (c1_alarm !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_alarm actual=%b required=0", c1_alarm);
    end
`endif
    tick();
    rst_n = 1'b1;
    // Idle with en low: pulses must not start anything.
    for (int c = 0; c < 4; c++) begin
      pulse = c[0];
      tick();
      n_compared++;
      if (c1_busy !== 1'b0 || c1_valid !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL idle_quiet cyc=%0d actual busy=%b valid=%b required 0 0", c, c1_busy, c1_valid);
      end
    end
  endtask

  task automatic test_nominal();
    logic exp_valid;
    start_from_reset(1'b0);
    enter_measure(1'b0);
    for (int c = 0; c < 48; c++) begin
      pulse = ((c % 4) == 0);
      tick();
      exp_valid = ((c % 16) == 15);
      n_compared++;
      if (c1_valid !== exp_valid || c1_busy !== 1'b1) begin
        n_mismatched++;
        $display("[TB] FAIL nominal_strobe cyc=%0d actual valid=%b busy=%b required valid=%b busy=1", c, c1_valid, c1_busy, exp_valid);
      end
      if (exp_valid) begin
        n_compared++;
        if (c1_count !== 8'd4 || c1_under !== 1'b0 || c1_over !== 1'b0) begin
          n_mismatched++;
          $display("[TB] FAIL nominal_report cyc=%0d actual count=%0d under=%b over=%b required 4 0 0", c, c1_count, c1_under, c1_over);
        end
        n_compared++;
        if (c2_count !== 3'd4 || c2_over !== 1'b0) begin
          n_mismatched++;
          $display("[TB] FAIL nominal_dut2 cyc=%0d actual count=%0d over=%b required 4 0", c, c2_count, c2_over);
        end
      end
    end
    en = 1'b0;
    pulse = 1'b0;
    tick();
    n_compared++;
    if (c1_busy !== 1'b0 || c1_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL nominal_stop actual busy=%b valid=%b required 0 0", c1_busy, c1_valid);
    end
  endtask

  task automatic test_const_high();
    start_from_reset(1'b1);
    enter_measure(1'b1);
    for (int c = 0; c < 32; c++) begin
      pulse = 1'b1;
      tick();
      if ((c % 16) == 15) begin
        n_compared++;
        if (c1_valid !== 1'b1 || c1_count !== 8'd0 || c1_under !== 1'b1 || c1_over !== 1'b0) begin
          n_mismatched++;
          $display("[TB] FAIL const_high cyc=%0d actual valid=%b count=%0d under=%b over=%b required 1 0 1 0", c, c1_valid, c1_count, c1_under, c1_over);
        end
      end
    end
    en = 1'b0;
    pulse = 1'b0;
    tick();
  endtask

  task automatic test_saturate();
    start_from_reset(1'b0);
    enter_measure(1'b0);
    for (int c = 0; c < 32; c++) begin
      pulse = ((c % 2) == 0);
      tick();
      if ((c % 16) == 15) begin
        n_compared++;
        if (c2_valid !== 1'b1 || c2_count !== 3'd7 || c2_over !== 1'b1 || c2_under !== 1'b0) begin
          n_mismatched++;
          $display("[TB] FAIL saturate_dut2 cyc=%0d actual valid=%b count=%0d over=%b under=%b required 1 7 1 0", c, c2_valid, c2_count, c2_over, c2_under);
        end
        n_compared++;
        if (c1_count !== 8'd8 || c1_over !== 1'b1) begin
          n_mismatched++;
          $display("[TB] FAIL saturate_dut1 cyc=%0d actual count=%0d over=%b required 8 1", c, c1_count, c1_over);
        end
      end
    end
    en = 1'b0;
    pulse = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    logic exp_valid;
    start_from_reset(1'b0);
    enter_measure(1'b0);
    // First window: pulses at cycles 1, 5, 9 -> count 3.
    for (int w = 0; w < 16; w++) begin
      pulse = (w == 1) || (w == 5) || (w == 9);
      tick();
    end
    n_compared++;
    if (c1_valid !== 1'b1 || c1_count !== 8'd3) begin
      n_mismatched++;
      $display("[TB] FAIL abort_prior actual valid=%b count=%0d required 1 3", c1_valid, c1_count);
    end
    // Second window: run cycles 0..9, then drop en during cycle 10.
    for (int w = 0; w < 10; w++) begin
      pulse = (w == 2);
      tick();
    end
    en = 1'b0;
    pulse = 1'b0;
    tick();
    n_compared++;
    if (c1_busy !== 1'b0 || c1_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL abort_idle actual busy=%b valid=%b required 0 0", c1_busy, c1_valid);
    end
    for (int c = 0; c < 20; c++) begin
      pulse = ((c % 3) == 0);
      tick();
      n_compared++;
      if (c1_valid !== 1'b0 || c1_count !== 8'd3) begin
        n_mismatched++;
        $display("[TB] FAIL abort_hold cyc=%0d actual valid=%b count=%0d required 0 3", c, c1_valid, c1_count);
      end
    end
    // Re-enable: pulses at 0, 3, 6, 9, 12 -> count 5, reported after 16 cycles.
    pulse = 1'b0;
    enter_measure(1'b0);
    for (int w = 0; w < 16; w++) begin
      pulse = (w < 15) && ((w % 3) == 0);
      tick();
      exp_valid = (w == 15);
      n_compared++;
      if (c1_valid !== exp_valid) begin
        n_mismatched++;
        $display("[TB] FAIL reenable_valid w=%0d actual=%b required=%b", w, c1_valid, exp_valid);
      end
    end
    n_compared++;
    if (c1_count !== 8'd5 || c1_under !== 1'b0 || c1_over !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reenable_report actual count=%0d under=%b over=%b required 5 0 0", c1_count, c1_under, c1_over);
    end
    en = 1'b0;
    pulse = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_cnt [3];
    exp_cnt[0] = 8'd1;
    exp_cnt[1] = 8'd0;
    exp_cnt[2] = 8'd1;
    start_from_reset(1'b0);
    enter_measure(1'b0);
    // Edge on last cycle of window 0; level still high into window 1 (no edge);
    // fresh edge on first cycle of window 2.
    for (int c = 0; c < 48; c++) begin
      pulse = (c == 15) || (c == 16) || (c == 32);
      tick();
      if ((c % 16) == 15) begin
        n_compared++;
        if (c1_valid !== 1'b1 || c1_count !== exp_cnt[c / 16] || c1_under !== 1'b1) begin
          n_mismatched++;
          $display("[TB] FAIL boundary win=%0d actual valid=%b count=%0d under=%b required 1 %0d 1", c / 16, c1_valid, c1_count, c1_under, exp_cnt[c / 16]);
        end
      end
    end
    en = 1'b0;
    pulse = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    start_from_reset(1'b0);
    enter_measure(1'b0);
    for (int c = 0; c < 21; c++) begin
      pulse = ((c % 2) == 0);
      tick();
    end
    n_compared++;
    if (c1_count !== 8'd8 || c1_over !== 1'b1 || c1_busy !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_pre actual count=%0d over=%b busy=%b required 8 1 1", c1_count, c1_over, c1_busy);
    end
    #3 rst_n = 1'b0;
    #1;
    n_compared++;
    if ({c1_count, c1_valid, c1_under, c1_over, c1_busy} !== 12'h000) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_dut1 actual=%h/%b%b%b%b required=00/0000", c1_count, c1_valid, c1_under, c1_over, c1_busy);
    end
    n_compared++;
    if ({c2_count, c2_over, c2_busy} !== 5'h00) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_dut2 actual=%h/%b%b required=0/00", c2_count, c2_over, c2_busy);
    end
    tick();
    tick();
    rst_n = 1'b1;
    pulse = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_compared++;
      if (c1_valid !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL midreset_noreport cyc=%0d actual=%b required=0", c, c1_valid);
      end
    end
    en = 1'b0;
    tick();
  endtask

`ifdef PULSE_RATE_MON_ALARM_EN
  task automatic test_alarm();
    logic exp_alarm;
    start_from_reset(1'b0);
    enter_measure(1'b0);
    for (int w = 0; w < 16; w++) begin
      pulse = 1'b0;
      tick();
    end
    n_compared++;
    if (c1_valid !== 1'b1 || c1_under !== 1'b1 || c1_alarm !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL alarm_set actual valid=%b under=%b alarm=%b required 1 1 1", c1_valid, c1_under, c1_alarm);
    end
    // Clear at cycle 3; clear again at cycle 15 where another under report lands.
    for (int w = 0; w < 16; w++) begin
      alarm_clr = (w == 3) || (w == 15);
      tick();
      exp_alarm = (w < 3) || (w == 15);
      n_compared++;
      if (c1_alarm !== exp_alarm) begin
        n_mismatched++;
        $display("[TB] FAIL alarm_clear w=%0d actual=%b required=%b", w, c1_alarm, exp_alarm);
      end
    end
    alarm_clr = 1'b0;
    en = 1'b0;
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_nominal();
    test_const_high();
    test_saturate();
    test_abort();
    test_back_to_back();
    test_reset_mid();
`ifdef PULSE_RATE_MON_ALARM_EN
    test_alarm();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
